bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants allowed while inst_req is pending.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have inst-side ports, all sram-like:
- inst_req, input, 1
- inst_addr, input, 32
- inst_addr_ok, output, 1
- inst_data_ok, output, 1
- inst_rdata, output, 32
REQ-005 SHALL have data-side ports, all sram-like:
- data_req, input, 1
- data_wr, input, 1
- data_size, input, 2
- data_addr, input, 32
- data_wstrb, input, 4
- data_wdata, input, 32
- data_addr_ok, output, 1
- data_data_ok, output, 1
- data_rdata, output, 32
REQ-006 SHALL have downstream master ports:
- m_req, output, 1
- m_wr, output, 1
- m_size, output, 2
- m_addr, output, 32
- m_wstrb, output, 4
- m_wdata, output, 32
- m_addr_ok, input, 1
- m_data_ok, input, 1
- m_rdata, input, 32
REQ-007 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-008 SHALL implement a 3-state FSM with states IDLE, ADDR and DATA, and SHALL allow at most one outstanding downstream transaction.
REQ-009 SHALL arbitrate in IDLE whenever inst_req or data_req is high; on that edge it latches the winner's fields and owner, then enters ADDR, so m_req rises one cycle after the request is sampled.
REQ-010 SHALL grant data over inst unless starve_cnt == STARVE_LIMIT and inst_req is high, in which case inst wins.
REQ-011 SHALL manage starve_cnt as follows:
- +1 on each data grant while inst_req is high, saturating at STARVE_LIMIT
- cleared on an inst grant
- cleared on a data grant while inst_req is low
REQ-012 SHALL drive the latched inst grant downstream as m_wr=0, m_size=2'b10, m_addr=latched inst_addr, m_wstrb=4'b0000, m_wdata=0.
REQ-013 SHALL drive a latched data grant downstream using the latched data_wr, data_size, data_addr, data_wstrb and data_wdata.
REQ-014 SHALL hold m_req=1 and the m_* fields stable throughout ADDR, and SHALL hold m_req=0 in IDLE and DATA.
REQ-015 SHALL, in ADDR with m_addr_ok=1, pulse the owner's addr_ok combinationally in the same cycle and move to DATA; a non-owner's addr_ok stays 0.
REQ-016 SHALL ignore m_data_ok while in ADDR.
REQ-017 SHALL, in DATA with m_data_ok=1, pulse the owner's data_ok combinationally in the same cycle.
REQ-018 SHALL, on that same m_data_ok cycle, re-arbitrate and go directly to ADDR if any request is pending (2-cycle minimum per transfer); otherwise it goes to IDLE.
REQ-019 SHALL drive inst_rdata and data_rdata continuously from m_rdata; they are meaningful only while the matching data_ok is high.
REQ-020 SHALL complete a granted transaction even if the requester deasserts req before addr_ok, because the fields are latched.
REQ-021 SHALL treat requests that arrive while in ADDR or DATA as pending; they are not acknowledged until granted.
REQ-022 SHALL resolve simultaneous inst_req and data_req in IDLE per REQ-010; the loser's req is held and served at the next arbitration point.

Reset
REQ-023 SHALL, while resetn=0, force asynchronously:
- FSM to IDLE and starve_cnt to 0
- m_req, all addr_ok/data_ok outputs, m_wr, m_size, m_addr, m_wstrb, m_wdata and busy to 0
REQ-024 SHALL abandon any in-flight transaction if reset is asserted mid-transaction; after resetn rises, the first arbitration occurs in IDLE.

Verification
REQ-025 SHALL cover an inst-only read: inst_req=1, addr=0xBFC00000, m_addr_ok at cycle+2, m_data_ok at cycle+4 with m_rdata=0x3C010001 -> m_req high in cycles +1..+2, m_addr=0xBFC00000, m_wr=0, inst_addr_ok at +2, inst_data_ok at +4, inst_rdata=0x3C010001.
REQ-026 SHALL cover simultaneous requests: inst_req and data_req both high in IDLE with data_wr=1, addr=0x80000010, wstrb=4'b0011 -> data granted first with m_wstrb=4'b0011; inst granted on the data_ok cycle and m_req reasserted with m_addr=inst_addr in the next cycle.
REQ-027 SHALL cover starvation: inst_req and data_req both held high for 6 transfers with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D.
REQ-028 SHALL cover back-to-back data: data_req held with m_addr_ok and m_data_ok each asserted on the first eligible cycle -> one completed transfer every 2 cycles and busy stays 1 throughout.
REQ-029 SHALL cover reset in DATA: resetn=0 while waiting for m_data_ok -> m_req=0, busy=0, no data_ok pulse; after release, a fresh inst_req completes normally.
REQ-030 SHALL cover a stray m_data_ok in ADDR: m_data_ok=1 with m_addr_ok=0 -> no data_ok pulse and the FSM stays in ADDR.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter merging an sram-like instruction port and data port onto one
// downstream sram-like master, with data priority bounded by a starvation limit.
module bus_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t          state_r;
   logic            ownerData_r;
   logic [CW-1:0]   starveCnt_r;

   logic            anyReq_s;
   logic            grantInst_s;
   logic            loadGrant_s;
   logic            nxtWr_s;
   logic [1:0]      nxtSize_s;
   logic [31:0]     nxtAddr_s;
   logic [3:0]      nxtWstrb_s;
   logic [31:0]     nxtWdata_s;
   logic [CW-1:0]   nxtStarve_s;

   // Arbitration decision and the field set the winner would load.
   always_comb begin
      anyReq_s    = inst_req | data_req;
      grantInst_s = inst_req & (~data_req | (starveCnt_r == LIMIT));
      loadGrant_s = anyReq_s & ((state_r == IDLE) | ((state_r == DATA) & m_data_ok));
      if (grantInst_s) begin
         nxtWr_s     = 1'b0;
         nxtSize_s   = 2'b10;
         nxtAddr_s   = inst_addr;
         nxtWstrb_s  = 4'b0000;
         nxtWdata_s  = 32'h0000_0000;
         nxtStarve_s = {CW{1'b0}};
      end else begin
         nxtWr_s    = data_wr;
         nxtSize_s  = data_size;
         nxtAddr_s  = data_addr;
         nxtWstrb_s = data_wstrb;
         nxtWdata_s = data_wdata;
         // Only a data win that overtakes a waiting inst request counts toward starvation.
         if (!inst_req) begin
            nxtStarve_s = {CW{1'b0}};
         end else if (starveCnt_r == LIMIT) begin
            nxtStarve_s = LIMIT;
         end else begin
            nxtStarve_s = starveCnt_r + CW'(1);
         end
      end
   end

   // Handshake strobes are combinational so the requester sees them in the downstream cycle.
   always_comb begin
      inst_addr_ok = (state_r == ADDR) & m_addr_ok & ~ownerData_r;
      data_addr_ok = (state_r == ADDR) & m_addr_ok & ownerData_r;
      inst_data_ok = (state_r == DATA) & m_data_ok & ~ownerData_r;
      data_data_ok = (state_r == DATA) & m_data_ok & ownerData_r;
      inst_rdata   = m_rdata;
      data_rdata   = m_rdata;
   end

   // Transaction FSM with registered downstream request fields.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= IDLE;
         ownerData_r <= 1'b0;
         starveCnt_r <= {CW{1'b0}};
         m_req       <= 1'b0;
         m_wr        <= 1'b0;
         m_size      <= 2'b00;
         m_addr      <= 32'h0000_0000;
         m_wstrb     <= 4'b0000;
         m_wdata     <= 32'h0000_0000;
         busy        <= 1'b0;
      end else if (loadGrant_s) begin
         state_r     <= ADDR;
         ownerData_r <= ~grantInst_s;
         starveCnt_r <= nxtStarve_s;
         m_req       <= 1'b1;
         m_wr        <= nxtWr_s;
         m_size      <= nxtSize_s;
         m_addr      <= nxtAddr_s;
         m_wstrb     <= nxtWstrb_s;
         m_wdata     <= nxtWdata_s;
         busy        <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               m_req <= 1'b0;
               busy  <= 1'b0;
            end
            ADDR: begin
               // m_data_ok is deliberately ignored until the address phase completes.
               if (m_addr_ok) begin
                  state_r <= DATA;
                  m_req   <= 1'b0;
               end
            end
            DATA: begin
               if (m_data_ok) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               m_req   <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a transaction-level model.
module tb_bus_arbiter;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic        m_req, m_wr, m_addr_ok, m_data_ok, busy;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;

   int checks = 0;
   int passes = 0;

   bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
      .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
   endtask

   // Transaction-level model: one outstanding transfer described by its phase and owner.
   int          mdlPhase;     // 0 = nothing outstanding, 1 = waiting for address accept, 2 = waiting for data
   bit          mdlOwnData;
   bit          mdlWr;
   logic [1:0]  mdlSize;
   logic [31:0] mdlAddr, mdlWdata;
   logic [3:0]  mdlWstrb;
   int          mdlStarve;

   task automatic mdlArbitrate();
      if (!inst_req && !data_req) begin
         mdlPhase = 0;
      end else if (data_req && !(inst_req && mdlStarve == STARVE_LIMIT)) begin
         mdlPhase = 1; mdlOwnData = 1'b1;
         mdlWr = data_wr; mdlSize = data_size; mdlAddr = data_addr;
         mdlWstrb = data_wstrb; mdlWdata = data_wdata;
         mdlStarve = inst_req ? ((mdlStarve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mdlStarve + 1) : 0;
      end else begin
         mdlPhase = 1; mdlOwnData = 1'b0;
         mdlWr = 1'b0; mdlSize = 2'b10; mdlAddr = inst_addr;
         mdlWstrb = 4'b0000; mdlWdata = 32'h0; mdlStarve = 0;
      end
   endtask

   always @(negedge clk) begin
      if (!resetn) begin
         mdlPhase = 0; mdlOwnData = 1'b0; mdlWr = 1'b0; mdlSize = 2'b00;
         mdlAddr = 32'h0; mdlWstrb = 4'b0000; mdlWdata = 32'h0; mdlStarve = 0;
      end
      chk("mdl_m_req", {31'h0, m_req}, {31'h0, mdlPhase == 1});
      chk("mdl_busy", {31'h0, busy}, {31'h0, mdlPhase != 0});
      chk("mdl_inst_addr_ok", {31'h0, inst_addr_ok}, {31'h0, mdlPhase == 1 && m_addr_ok && !mdlOwnData});
      chk("mdl_data_addr_ok", {31'h0, data_addr_ok}, {31'h0, mdlPhase == 1 && m_addr_ok && mdlOwnData});
      chk("mdl_inst_data_ok", {31'h0, inst_data_ok}, {31'h0, mdlPhase == 2 && m_data_ok && !mdlOwnData});
      chk("mdl_data_data_ok", {31'h0, data_data_ok}, {31'h0, mdlPhase == 2 && m_data_ok && mdlOwnData});
      chk("mdl_inst_rdata", inst_rdata, m_rdata);
      chk("mdl_data_rdata", data_rdata, m_rdata);
      if (mdlPhase == 1 || !resetn) begin
         chk("mdl_m_wr", {31'h0, m_wr}, {31'h0, mdlWr});
         chk("mdl_m_size", {30'h0, m_size}, {30'h0, mdlSize});
         chk("mdl_m_addr", m_addr, mdlAddr);
         chk("mdl_m_wstrb", {28'h0, m_wstrb}, {28'h0, mdlWstrb});
         chk("mdl_m_wdata", m_wdata, mdlWdata);
      end
      if (resetn) begin
         if (mdlPhase == 0) mdlArbitrate();
         else if (mdlPhase == 1) begin if (m_addr_ok) mdlPhase = 2; end
         else if (m_data_ok) mdlArbitrate();
      end
   end

   task automatic nextCyc();
      @(posedge clk);
      #1;
   endtask

   task automatic instRead(input logic [31:0] a, input logic [31:0] d);
      inst_req = 1'b1; inst_addr = a;
      @(negedge clk); chk("ir_c0_m_req", {31'h0, m_req}, 32'h0);
      nextCyc(); inst_req = 1'b0;
      @(negedge clk);
      chk("ir_c1_m_req", {31'h0, m_req}, 32'h1);
      chk("ir_c1_m_addr", m_addr, a);
      chk("ir_c1_m_wr", {31'h0, m_wr}, 32'h0);
      chk("ir_c1_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
      nextCyc(); m_addr_ok = 1'b1;
      @(negedge clk);
      chk("ir_c2_m_req", {31'h0, m_req}, 32'h1);
      chk("ir_c2_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
      nextCyc(); m_addr_ok = 1'b0;
      @(negedge clk);
      chk("ir_c3_m_req", {31'h0, m_req}, 32'h0);
      chk("ir_c3_data_ok", {31'h0, inst_data_ok}, 32'h0);
      nextCyc(); m_data_ok = 1'b1; m_rdata = d;
      @(negedge clk);
      chk("ir_c4_data_ok", {31'h0, inst_data_ok}, 32'h1);
      chk("ir_c4_rdata", inst_rdata, d);
      chk("ir_c4_dside_ok", {31'h0, data_data_ok}, 32'h0);
      nextCyc(); m_data_ok = 1'b0;
      @(negedge clk); chk("ir_c5_busy", {31'h0, busy}, 32'h0);
      nextCyc();
   endtask

   initial begin
      byte grants[$];
      string expOrder;
      int nDone;
      resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
      data_size = 2'b00; data_addr = 32'h0; data_wstrb = 4'b0000; data_wdata = 32'h0;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_req", {31'h0, m_req}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_m_addr", m_addr, 32'h0);
      nextCyc(); resetn = 1'b1;

      instRead(32'hBFC0_0000, 32'h3C01_0001);

      // Simultaneous requests: data first, inst re-granted on the data_ok edge.
      inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'b10; data_addr = 32'h8000_0010;
      data_wstrb = 4'b0011; data_wdata = 32'h1234_5678;
      nextCyc(); data_req = 1'b0; m_addr_ok = 1'b1;
      @(negedge clk);
      chk("sim_m_wstrb", {28'h0, m_wstrb}, 32'h3);
      chk("sim_m_addr_d", m_addr, 32'h8000_0010);
      chk("sim_m_wr", {31'h0, m_wr}, 32'h1);
      chk("sim_data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
      chk("sim_inst_addr_ok", {31'h0, inst_addr_ok}, 32'h0);
      nextCyc(); m_addr_ok = 1'b0; m_data_ok = 1'b1;
      @(negedge clk); chk("sim_data_data_ok", {31'h0, data_data_ok}, 32'h1);
      nextCyc(); m_data_ok = 1'b0; inst_req = 1'b0;
      @(negedge clk);
      chk("sim_m_req_i", {31'h0, m_req}, 32'h1);
      chk("sim_m_addr_i", m_addr, 32'hBFC0_0100);
      chk("sim_m_size_i", {30'h0, m_size}, 32'h2);
      nextCyc(); m_addr_ok = 1'b1;
      nextCyc(); m_addr_ok = 1'b0; m_data_ok = 1'b1;
      nextCyc(); m_data_ok = 1'b0;
      nextCyc();

      // Starvation: both requests held with immediate acknowledges.
      inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; m_addr_ok = 1'b1; m_data_ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (inst_addr_ok) grants.push_back("I");
         if (data_addr_ok) grants.push_back("D");
         nextCyc();
      end
      inst_req = 1'b0; data_req = 1'b0;
      nextCyc(); m_addr_ok = 1'b0; m_data_ok = 1'b0;
      nextCyc();
      expOrder = "DDDDID";
      chk("starve_count", grants.size(), 6);
      for (int i = 0; i < 6; i++)
         chk("starve_order", (i < grants.size()) ? {24'h0, grants[i]} : 32'h0, {24'h0, expOrder[i]});

      // Back-to-back data transfers.
      data_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1; nDone = 0;
      for (int i = 1; i <= 10; i++) begin
         nextCyc();
         if (i == 10) data_req = 1'b0;
         @(negedge clk);
         chk("b2b_busy", {31'h0, busy}, 32'h1);
         if (data_data_ok) nDone++;
      end
      nextCyc(); m_addr_ok = 1'b0; m_data_ok = 1'b0;
      chk("b2b_done", nDone, 5);
      nextCyc();

      // Stray m_data_ok during the address phase.
      inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
      nextCyc(); inst_req = 1'b0; m_data_ok = 1'b1;
      @(negedge clk); chk("stray_data_ok", {31'h0, inst_data_ok}, 32'h0);
      nextCyc();
      @(negedge clk); chk("stray_m_req", {31'h0, m_req}, 32'h1);
      nextCyc(); m_data_ok = 1'b0; m_addr_ok = 1'b1;
      @(negedge clk); chk("stray_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
      nextCyc(); m_addr_ok = 1'b0; m_data_ok = 1'b1;
      @(negedge clk); chk("stray_done", {31'h0, inst_data_ok}, 32'h1);
      nextCyc(); m_data_ok = 1'b0;
      nextCyc();

      // Reset while waiting for data.
      data_req = 1'b1; data_addr = 32'h8000_1000;
      nextCyc(); data_req = 1'b0; m_addr_ok = 1'b1;
      nextCyc(); m_addr_ok = 1'b0;
      @(negedge clk); chk("rstd_busy_pre", {31'h0, busy}, 32'h1);
      nextCyc(); resetn = 1'b0; m_data_ok = 1'b1;
      @(negedge clk);
      chk("rstd_m_req", {31'h0, m_req}, 32'h0);
      chk("rstd_busy", {31'h0, busy}, 32'h0);
      chk("rstd_data_ok", {31'h0, data_data_ok}, 32'h0);
      nextCyc(); m_data_ok = 1'b0; resetn = 1'b1;
      nextCyc();
      instRead(32'hBFC0_0040, 32'h0000_ABCD);

      // Random phase, checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         inst_req   = ($urandom_range(0, 2) == 0);
         inst_addr  = $urandom;
         data_req   = ($urandom_range(0, 2) == 0);
         data_wr    = 1'($urandom_range(0, 1));
         data_size  = 2'($urandom_range(0, 3));
         data_addr  = $urandom;
         data_wstrb = 4'($urandom_range(0, 15));
         data_wdata = $urandom;
         m_addr_ok  = ($urandom_range(0, 1) == 1);
         m_data_ok  = ($urandom_range(0, 1) == 1);
         m_rdata    = $urandom;
         resetn     = ($urandom_range(0, 199) != 0);
         nextCyc();
      end
      inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; resetn = 1'b1;
      nextCyc();
      @(negedge clk);
      nextCyc();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
